// File: rtl/prog_loader_if.sv
// Byte stream handshake between a host/debug source and the program loader.
// Transfer happens on any cycle where in_valid & in_ready.
interface prog_loader_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Program memory writer: framed byte stream -> instruction ROM write port.
// Holds the CPU in reset while loading and releases it on a good checksum.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         AW        = 8,
    parameter int         DW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  stream,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] byte_count
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [DW:0]   remaining;
    logic [DW-1:0] xsum;
    logic          xfer;

    // Memory write is single-cycle, so the loader never backpressures.
    assign stream.in_ready = 1'b1;
    assign xfer = stream.in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            xsum       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                unique case (state)
                    IDLE: begin
                        if (stream.in_data == SYNC_BYTE) begin
                            state      <= ADDR;
                            cpu_hold   <= 1'b1;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            byte_count <= '0;
                            xsum       <= '0;
                        end
                    end
                    ADDR: begin
                        addr  <= AW'(stream.in_data);
                        state <= LEN;
                    end
                    LEN: begin
                        // A zero length byte encodes a full 256-byte payload.
                        if (stream.in_data == '0)
                            remaining <= {1'b1, {DW{1'b0}}};
                        else
                            remaining <= {1'b0, stream.in_data};
                        state <= DATA;
                    end
                    DATA: begin
                        mem_we     <= 1'b1;
                        mem_wdata  <= stream.in_data;
                        mem_addr   <= addr;
                        addr       <= addr + AW'(1);
                        xsum       <= xsum ^ stream.in_data;
                        byte_count <= byte_count + AW'(1);
                        remaining  <= remaining - (DW+1)'(1);
                        if (remaining == (DW+1)'(1))
                            state <= CSUM;
                    end
                    CSUM: begin
                        if (stream.in_data == xsum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
